// File: rtl/skein_core_sequencer.sv
// skein_core_sequencer: drives every control input of the single-MIX Skein-1024 core through
// a MSG pass and an OUT pass of Threefish-1024, then captures the digest.
module skein_core_sequencer #(
   parameter logic [63:0] TWEAK_MSG0 = 64'h0,
   parameter logic [63:0] TWEAK_MSG1 = 64'hF000_0000_0000_0000,
   parameter logic [63:0] TWEAK_OUT0 = 64'h8,
   parameter logic [63:0] TWEAK_OUT1 = 64'hFF00_0000_0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        input_register_write_o,
   output logic        output_register_plaintext_select_o,
   output logic [3:0]  word_o,
   output logic        x0_key_select_o,
   output logic [1:0]  x1_tweak_subkey_select_o,
   output logic [63:0] tweak_word_o,
   output logic [7:0]  rotate_constant_o,
   output logic [15:0] Y1_select_o,
   output logic [15:0] output_register_write_o,
   output logic        key_register_write_o,
   output logic        hash_mode_o,
   output logic        subkey_write_o,
   output logic [4:0]  subkey_o,
   output logic        hash_register_write_o
);
   typedef enum logic [2:0] {IDLE, LOAD, PREP, INJ, COPY_I, MIX, COPY_M, FF} state_t;
   localparam logic [7:0] ROT [64] = '{
      8'd24, 8'd13, 8'd8,  8'd47, 8'd8,  8'd17, 8'd22, 8'd37,
      8'd38, 8'd19, 8'd10, 8'd55, 8'd49, 8'd18, 8'd23, 8'd52,
      8'd33, 8'd4,  8'd51, 8'd13, 8'd34, 8'd41, 8'd59, 8'd17,
      8'd5,  8'd20, 8'd48, 8'd41, 8'd47, 8'd28, 8'd16, 8'd25,
      8'd41, 8'd9,  8'd37, 8'd31, 8'd12, 8'd47, 8'd44, 8'd30,
      8'd16, 8'd34, 8'd56, 8'd51, 8'd4,  8'd53, 8'd42, 8'd41,
      8'd31, 8'd44, 8'd47, 8'd46, 8'd19, 8'd42, 8'd44, 8'd25,
      8'd9,  8'd48, 8'd35, 8'd52, 8'd23, 8'd31, 8'd37, 8'd20};
   localparam logic [3:0] PI [16] = '{
      4'd0, 4'd9, 4'd2, 4'd13, 4'd6, 4'd11, 4'd4, 4'd15,
      4'd10, 4'd7, 4'd12, 4'd3, 4'd14, 4'd5, 4'd8, 4'd1};
   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [4:0]  s, s_n;
   logic [6:0]  d, d_n;
   logic        pass_out, pass_n;
   logic [63:0] t0, t1;
   logic [5:0]  pm;
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         cnt      <= '0;
         s        <= '0;
         d        <= '0;
         pass_out <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         s        <= s_n;
         d        <= d_n;
         pass_out <= pass_n;
      end
   end
   always_comb begin
      state_n = state;
      cnt_n = '0;
      s_n = s;
      d_n = d;
      pass_n = pass_out;
      busy_o = state != IDLE;
      hash_mode_o = !pass_out;
      done_o = 1'b0;
      input_register_write_o = 1'b0;
      output_register_plaintext_select_o = 1'b0;
      word_o = '0;
      x0_key_select_o = 1'b0;
      x1_tweak_subkey_select_o = '0;
      tweak_word_o = '0;
      rotate_constant_o = '0;
      Y1_select_o = '0;
      output_register_write_o = '0;
      key_register_write_o = 1'b0;
      subkey_write_o = 1'b0;
      subkey_o = '0;
      hash_register_write_o = 1'b0;
      t0 = pass_out ? TWEAK_OUT0 : TWEAK_MSG0;
      t1 = pass_out ? TWEAK_OUT1 : TWEAK_MSG1;
      pm = ({1'b0, s} + {4'b0, cnt[1:0]}) % 6'd3;
      case (state)
         IDLE: begin
            state_n = start_i ? LOAD : IDLE;
            pass_n = 1'b0;
         end
         LOAD: begin
            state_n = PREP;
            s_n = '0;
            d_n = '0;
            input_register_write_o = 1'b1;
            output_register_plaintext_select_o = 1'b1;
         end
         PREP: begin
            state_n = cnt == 4'd2 ? INJ : PREP;
            cnt_n = cnt == 4'd2 ? 4'd0 : cnt + 4'd1;
            word_o = 4'd13 + cnt;
            x0_key_select_o = 1'b1;
            x1_tweak_subkey_select_o = 2'd1;
            subkey_write_o = 1'b1;
            subkey_o = s;
            tweak_word_o = cnt[1] ? {59'b0, s} : pm == 6'd0 ? t0 : pm == 6'd1 ? t1 : t0 ^ t1;
         end
         INJ: begin
            state_n = cnt == 4'd15 ? COPY_I : INJ;
            cnt_n = cnt + 4'd1;
            word_o = cnt;
            x1_tweak_subkey_select_o = 2'd2;
            subkey_o = s;
            output_register_write_o = 16'd1 << cnt;
         end
         MIX: begin
            state_n = cnt == 4'd7 ? COPY_M : MIX;
            cnt_n = cnt == 4'd7 ? 4'd0 : cnt + 4'd1;
            word_o = cnt;
            rotate_constant_o = ROT[{d[2:0], cnt[2:0]}];
            // Each MIX pair (2j,2j+1) lands in the permuted slots holding those words.
            for (int i = 0; i < 16; i++) begin
               output_register_write_o[i] = PI[i][3:1] == cnt[2:0];
               Y1_select_o[i] = PI[i] == {cnt[2:0], 1'b1};
            end
         end
         COPY_I: begin
            state_n = s == 5'd20 ? FF : MIX;
            s_n = s + 5'd1;
            input_register_write_o = 1'b1;
         end
         COPY_M: begin
            state_n = d[1:0] == 2'd3 ? PREP : MIX;
            d_n = d + 7'd1;
            input_register_write_o = 1'b1;
         end
         FF: begin
            state_n = pass_out ? IDLE : LOAD;
            pass_n = !pass_out;
            key_register_write_o = !pass_out;
            hash_register_write_o = pass_out;
            done_o = pass_out;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_skein_core_sequencer.sv
// tb_skein_core_sequencer: compares every control output, every cycle, against a model that
// derives the expected controls directly from the cycle's position within the job.
module tb_skein_core_sequencer;
   localparam logic [63:0] MSG0 = 64'h0;
   localparam logic [63:0] MSG1 = 64'hF000_0000_0000_0000;
   localparam logic [63:0] OUT0 = 64'h8;
   localparam logic [63:0] OUT1 = 64'hFF00_0000_0000_0000;
   localparam int R [64] = '{
      24, 13, 8, 47, 8, 17, 22, 37,   38, 19, 10, 55, 49, 18, 23, 52,
      33, 4, 51, 13, 34, 41, 59, 17,  5, 20, 48, 41, 47, 28, 16, 25,
      41, 9, 37, 31, 12, 47, 44, 30,  16, 34, 56, 51, 4, 53, 42, 41,
      31, 44, 47, 46, 19, 42, 44, 25, 9, 48, 35, 52, 23, 31, 37, 20};
   localparam int PI [16] = '{0, 9, 2, 13, 6, 11, 4, 15, 10, 7, 12, 3, 14, 5, 8, 1};

   typedef struct packed {
      logic        busy, done, irw, ps;
      logic [3:0]  word;
      logic        x0;
      logic [1:0]  x1;
      logic [63:0] tw;
      logic [7:0]  rot;
      logic [15:0] y1, orw;
      logic        kw, hm, sw;
      logic [4:0]  sub;
      logic        hw;
   } outs_t;

   logic clk, rst_i, start_i;
   logic busy_o, done_o, input_register_write_o, output_register_plaintext_select_o;
   logic [3:0] word_o;
   logic x0_key_select_o;
   logic [1:0] x1_tweak_subkey_select_o;
   logic [63:0] tweak_word_o;
   logic [7:0] rotate_constant_o;
   logic [15:0] Y1_select_o, output_register_write_o;
   logic key_register_write_o, hash_mode_o, subkey_write_o, hash_register_write_o;
   logic [4:0] subkey_o;
   outs_t act;
   int checks = 0;
   int errors = 0;

   skein_core_sequencer dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
      .input_register_write_o(input_register_write_o),
      .output_register_plaintext_select_o(output_register_plaintext_select_o),
      .word_o(word_o), .x0_key_select_o(x0_key_select_o),
      .x1_tweak_subkey_select_o(x1_tweak_subkey_select_o), .tweak_word_o(tweak_word_o),
      .rotate_constant_o(rotate_constant_o), .Y1_select_o(Y1_select_o),
      .output_register_write_o(output_register_write_o),
      .key_register_write_o(key_register_write_o), .hash_mode_o(hash_mode_o),
      .subkey_write_o(subkey_write_o), .subkey_o(subkey_o),
      .hash_register_write_o(hash_register_write_o));

   assign act = {busy_o, done_o, input_register_write_o, output_register_plaintext_select_o,
                 word_o, x0_key_select_o, x1_tweak_subkey_select_o, tweak_word_o,
                 rotate_constant_o, Y1_select_o, output_register_write_o,
                 key_register_write_o, hash_mode_o, subkey_write_o, subkey_o,
                 hash_register_write_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs at cycle k of a job (k=0 is the first LOAD); k<0 means idle.
   function automatic outs_t model(input int k);
      outs_t e;
      int pass, r, q, s, o, p, w, m, j, dd;
      logic [63:0] t [3];
      e = '0;
      e.hm = 1'b1;
      if (k < 0) return e;
      pass = k / 1142;
      r = k % 1142;
      e.busy = 1'b1;
      e.hm = pass == 0;
      t[0] = pass != 0 ? OUT0 : MSG0;
      t[1] = pass != 0 ? OUT1 : MSG1;
      t[2] = t[0] ^ t[1];
      if (r == 0) begin
         e.irw = 1'b1;
         e.ps = 1'b1;
      end else if (r == 1141) begin
         e.kw = pass == 0;
         e.hw = pass != 0;
         e.done = pass != 0;
      end else begin
         q = r - 1;
         s = q / 56;
         o = q % 56;
         if (o < 3) begin
            p = o;
            e.word = 4'(13 + p);
            e.x0 = 1'b1;
            e.x1 = 2'd1;
            e.sw = 1'b1;
            e.sub = 5'(s);
            e.tw = p < 2 ? t[(s + p) % 3] : 64'(s);
         end else if (o < 19) begin
            w = o - 3;
            e.word = 4'(w);
            e.x1 = 2'd2;
            e.sub = 5'(s);
            e.orw = 16'(1 << w);
         end else if (o == 19 || (o - 20) % 9 == 8) begin
            e.irw = 1'b1;
         end else begin
            m = (o - 20) / 9;
            j = (o - 20) % 9;
            dd = 4 * s + m;
            e.word = 4'(j);
            e.rot = 8'(R[(dd % 8) * 8 + j]);
            for (int i = 0; i < 16; i++) begin
               e.orw[i] = PI[i] / 2 == j;
               e.y1[i] = PI[i] == 2 * j + 1;
            end
         end
      end
      return e;
   endfunction

   task automatic pulse_start();
      repeat ($urandom_range(1, 4)) @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      start_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (act !== model(-1)) begin
            errors++;
            $display("FAIL reset_state cycle=%0d act=%h exp=%h", c, act, model(-1));
         end
      end
      rst_i = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      checks++;
      if (act !== model(-1)) begin
         errors++;
         $display("FAIL reset_start_lost act=%h exp=%h", act, model(-1));
      end
   endtask

   // Runs from the LOAD cycle through the idle cycle after done.
   task automatic run_job(input bit hold);
      int kn, kc, dn, dc;
      kn = 0; kc = -1; dn = 0; dc = -1;
      for (int k = 0; k < 2284; k++) begin
         checks++;
         if (act !== model(k)) begin
            errors++;
            $display("FAIL job_cycle k=%0d act=%h exp=%h", k, act, model(k));
         end
         if (k == 21) begin
            checks++;
            if (rotate_constant_o !== 8'd24 || output_register_write_o !== 16'h8001 ||
                Y1_select_o !== 16'h8000 || word_o !== 4'd0) begin
               errors++;
               $display("FAIL first_mix rot=%0d orw=%h y1=%h word=%0d required 24 8001 8000 0",
                        rotate_constant_o, output_register_write_o, Y1_select_o, word_o);
            end
         end
         if (k >= 57 && k <= 59) begin
            checks++;
            if (tweak_word_o !== (k == 57 ? MSG1 : k == 58 ? MSG0 ^ MSG1 : 64'h1) ||
                subkey_o !== 5'd1 || subkey_write_o !== 1'b1) begin
               errors++;
               $display("FAIL prep_s1 k=%0d tweak=%h subkey=%0d sw=%b", k, tweak_word_o,
                        subkey_o, subkey_write_o);
            end
         end
         if (key_register_write_o) begin kn++; kc = k; end
         if (done_o) begin dn++; dc = k; end
         start_i = hold ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      checks++;
      if (kn !== 1 || kc !== 1141) begin
         errors++;
         $display("FAIL key_write count=%0d at=%0d required 1 at 1141", kn, kc);
      end
      checks++;
      if (dn !== 1 || dc !== 2283) begin
         errors++;
         $display("FAIL done_pulse count=%0d at=%0d required 1 at 2283", dn, dc);
      end
      checks++;
      if (act !== model(-1)) begin
         errors++;
         $display("FAIL idle_after_done act=%h exp=%h", act, model(-1));
      end
      if (!hold) start_i = 1'b0;
   endtask

   task automatic test_job();
      pulse_start();
      run_job(1'b0);
   endtask

   task automatic test_reset_mid();
      int wr;
      pulse_start();
      for (int k = 0; k <= 581; k++) begin
         checks++;
         if (act !== model(k)) begin
            errors++;
            $display("FAIL pre_abort k=%0d act=%h exp=%h", k, act, model(k));
         end
         if (k < 581) @(negedge clk);
      end
      checks++;
      if (rotate_constant_o !== 8'd24 || word_o !== 4'd0 || output_register_write_o !== 16'h8001) begin
         errors++;
         $display("FAIL round40_mix rot=%0d word=%0d orw=%h", rotate_constant_o, word_o,
                  output_register_write_o);
      end
      rst_i = 1'b0;
      wr = 0;
      for (int c = 0; c < 4; c++) begin
         start_i = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (key_register_write_o || hash_register_write_o) wr++;
         checks++;
         if (act !== model(-1)) begin
            errors++;
            $display("FAIL abort_idle cycle=%0d act=%h exp=%h", c, act, model(-1));
         end
      end
      rst_i = 1'b1;
      start_i = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (key_register_write_o || hash_register_write_o || busy_o) wr++;
      end
      checks++;
      if (wr !== 0) begin
         errors++;
         $display("FAIL abort_no_write count=%0d required 0", wr);
      end
      pulse_start();
      run_job(1'b0);
   endtask

   task automatic test_back_to_back();
      repeat (2) @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      run_job(1'b1);
      @(negedge clk);
      checks++;
      if (act !== model(0)) begin
         errors++;
         $display("FAIL restart_from_idle act=%h exp=%h", act, model(0));
      end
      start_i = 1'b0;
      run_job(1'b0);
   endtask

   initial begin
      test_reset();
      test_job();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
